// File: rtl/mdu_unit_if.sv
//------------------------------------------------------------------------------
// Module   : mdu_unit_if
// Brief    : Command and result bundle between the E stage and the MDU.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface mdu_unit_if;
   logic        Start;
   logic [3:0]  MDUOp;
   logic [31:0] A;
   logic [31:0] B;
   logic        Busy;
   logic [31:0] Out;
   logic [31:0] HI;
   logic [31:0] LO;

   modport master (
      output Start, MDUOp, A, B,
      input  Busy, Out, HI, LO
   );

   modport slave (
      input  Start, MDUOp, A, B,
      output Busy, Out, HI, LO
   );
endinterface

`default_nettype wire

// File: rtl/mdu_unit.sv
//------------------------------------------------------------------------------
// Module   : mdu_unit
// Brief    : Multiply/divide unit owning HI/LO, with fixed multi-cycle latency.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module mdu_unit #(
   parameter int MULT_CYCLES      = 5,
   parameter int DIV_CYCLES       = 10,
   parameter bit CHECK_NO_RESTART = 1'b1
) (
   input  wire        clk,
   input  wire        rst_n,
   mdu_unit_if.slave  bus
);

   localparam logic [3:0] MDU_MULT  = 4'd1;
   localparam logic [3:0] MDU_MULTU = 4'd2;
   localparam logic [3:0] MDU_DIV   = 4'd3;
   localparam logic [3:0] MDU_DIVU  = 4'd4;
   localparam logic [3:0] MDU_MFHI  = 4'd5;
   localparam logic [3:0] MDU_MFLO  = 4'd6;
   localparam logic [3:0] MDU_MTHI  = 4'd7;
   localparam logic [3:0] MDU_MTLO  = 4'd8;

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic [31:0]       hi;
   logic [31:0]       lo;
   logic [31:0]       ph;
   logic [31:0]       pl;
   logic              pend_wr;

   logic              is_mul;
   logic              is_div;
   logic              launch;
   logic              finish;
   logic              idle_write;
   logic [31:0]       divisor;
   logic [63:0]       prod_s;
   logic [63:0]       prod_u;
   logic [31:0]       quot_s;
   logic [31:0]       rem_s;
   logic [31:0]       quot_u;
   logic [31:0]       rem_u;

   assign is_mul     = (bus.MDUOp == MDU_MULT) || (bus.MDUOp == MDU_MULTU);
   assign is_div     = (bus.MDUOp == MDU_DIV)  || (bus.MDUOp == MDU_DIVU);
   assign launch     = bus.Start && (state == IDLE) && (is_mul || is_div);
   assign finish     = (state == RUN) && (cnt == CNT_W'(1));
   assign idle_write = !bus.Start && (state == IDLE);

   // A zero divisor is replaced so the arithmetic stays defined; its result is discarded.
   assign divisor = (bus.B == 32'h0) ? 32'h1 : bus.B;

   assign prod_s = {{32{bus.A[31]}}, bus.A} * {{32{bus.B[31]}}, bus.B};
   assign prod_u = {32'h0, bus.A} * {32'h0, bus.B};
   assign quot_s = $signed(bus.A) / $signed(divisor);
   assign rem_s  = $signed(bus.A) % $signed(divisor);
   assign quot_u = bus.A / divisor;
   assign rem_u  = bus.A % divisor;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (launch) state_nxt = RUN;
         RUN:     if (finish) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt     <= '0;
         hi      <= 32'h0;
         lo      <= 32'h0;
         ph      <= 32'h0;
         pl      <= 32'h0;
         pend_wr <= 1'b0;
      end else begin
         if (launch) begin
            cnt     <= is_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
            pend_wr <= is_mul || (bus.B != 32'h0);
            case (bus.MDUOp)
               MDU_MULT:  begin ph <= prod_s[63:32]; pl <= prod_s[31:0]; end
               MDU_MULTU: begin ph <= prod_u[63:32]; pl <= prod_u[31:0]; end
               MDU_DIV:   begin ph <= rem_s;         pl <= quot_s;        end
               default:   begin ph <= rem_u;         pl <= quot_u;        end
            endcase
         end else if (state == RUN) begin
            cnt <= cnt - CNT_W'(1);
            if (finish && pend_wr) begin
               hi <= ph;
               lo <= pl;
            end
         end else if (idle_write) begin
            if (bus.MDUOp == MDU_MTHI) hi <= bus.A;
            if (bus.MDUOp == MDU_MTLO) lo <= bus.A;
         end
      end
   end

   assign bus.Busy = (state == RUN);
   assign bus.HI   = hi;
   assign bus.LO   = lo;

   // Reads see architectural HI/LO only; an in-flight result is never forwarded.
   always_comb begin
      bus.Out = 32'h0;
      if (bus.MDUOp == MDU_MFHI) bus.Out = hi;
      if (bus.MDUOp == MDU_MFLO) bus.Out = lo;
   end

`ifndef SYNTHESIS
   generate
      if (CHECK_NO_RESTART) begin : g_no_restart_chk
         always_ff @(posedge clk) begin
            if (rst_n && bus.Start && (state == RUN)) begin
               assert (!(is_mul || is_div))
                  else $error("mdu_unit: Start issued while an operation is in flight");
            end
         end
      end
   endgenerate
`endif

endmodule

`default_nettype wire

// File: tb/tb_mdu_unit.sv
//------------------------------------------------------------------------------
// Module   : tb_mdu_unit
// Brief    : Directed self-checking bench for mdu_unit with hand-computed results.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mdu_unit;

   localparam logic [3:0] MDU_NULL  = 4'd0;
   localparam logic [3:0] MDU_MULT  = 4'd1;
   localparam logic [3:0] MDU_MULTU = 4'd2;
   localparam logic [3:0] MDU_DIV   = 4'd3;
   localparam logic [3:0] MDU_DIVU  = 4'd4;
   localparam logic [3:0] MDU_MFHI  = 4'd5;
   localparam logic [3:0] MDU_MFLO  = 4'd6;
   localparam logic [3:0] MDU_MTHI  = 4'd7;
   localparam logic [3:0] MDU_MTLO  = 4'd8;

   logic        clk;
   logic        rst_n;
   int          n_vec;
   int          n_bad;
   logic [31:0] exp_hi;

   mdu_unit_if bus ();

   // The restart check is disabled because the bench deliberately drives Start during Busy.
   mdu_unit #(
      .MULT_CYCLES      (5),
      .DIV_CYCLES       (10),
      .CHECK_NO_RESTART (1'b0)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Launches one op, checks MFHI holds the pre-op HI during RUN, then measures Busy length.
   task automatic run_op(input string tag, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b, input int n);
      int cycles;
      bus.Start = 1'b1;
      bus.MDUOp = op;
      bus.A     = a;
      bus.B     = b;
      tick();
      bus.Start = 1'b0;
      bus.MDUOp = MDU_MFHI;
      bus.A     = 32'h0;
      bus.B     = 32'h0;
      #1;
      check({tag, "_hold_hi"}, bus.Out, exp_hi);
      cycles = 0;
      while (bus.Busy && cycles < 64) begin
         cycles++;
         tick();
      end
      check({tag, "_busy_len"}, 32'(cycles), 32'(n));
      bus.MDUOp = MDU_NULL;
   endtask

   initial begin
      int cycles;
      n_vec     = 0;
      n_bad     = 0;
      exp_hi    = 32'h0;
      rst_n     = 1'b0;
      bus.Start = 1'b0;
      bus.MDUOp = MDU_MFHI;
      bus.A     = 32'h0;
      bus.B     = 32'h0;

      repeat (2) tick();
      check("rst_hi",   bus.HI,   32'h0);
      check("rst_lo",   bus.LO,   32'h0);
      check("rst_busy", 32'(bus.Busy), 32'h0);
      check("rst_out",  bus.Out,  32'h0);
      rst_n     = 1'b1;
      bus.MDUOp = MDU_NULL;
      tick();

      run_op("mult", MDU_MULT, 32'hFFFF_FFFE, 32'd3, 5);
      check("mult_hi", bus.HI, 32'hFFFF_FFFF);
      check("mult_lo", bus.LO, 32'hFFFF_FFFA);
      exp_hi = 32'hFFFF_FFFF;

      run_op("multu", MDU_MULTU, 32'hFFFF_FFFE, 32'd3, 5);
      check("multu_hi", bus.HI, 32'h0000_0002);
      check("multu_lo", bus.LO, 32'hFFFF_FFFA);
      exp_hi = 32'h0000_0002;

      run_op("div", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 10);
      check("div_hi", bus.HI, 32'hFFFF_FFFF);
      check("div_lo", bus.LO, 32'hFFFF_FFFD);
      exp_hi = 32'hFFFF_FFFF;

      run_op("divu", MDU_DIVU, 32'd7, 32'd2, 10);
      check("divu_hi", bus.HI, 32'd1);
      check("divu_lo", bus.LO, 32'd3);
      exp_hi = 32'd1;

      bus.MDUOp = MDU_MTHI; bus.A = 32'h0000_1234; tick();
      bus.MDUOp = MDU_MTLO; bus.A = 32'h0000_5678; tick();
      bus.MDUOp = MDU_NULL; bus.A = 32'h0;
      check("mt_hi", bus.HI, 32'h0000_1234);
      check("mt_lo", bus.LO, 32'h0000_5678);
      exp_hi = 32'h0000_1234;

      run_op("div0", MDU_DIV, 32'd99, 32'd0, 10);
      check("div0_hi", bus.HI, 32'h0000_1234);
      check("div0_lo", bus.LO, 32'h0000_5678);

      bus.MDUOp = MDU_MTHI; bus.A = 32'hCAFE_0001; #1;
      check("mthi_pre_edge", bus.HI, 32'h0000_1234);
      tick();
      bus.MDUOp = MDU_MFHI; bus.A = 32'h0; #1;
      check("mfhi_out", bus.Out, 32'hCAFE_0001);
      bus.MDUOp = MDU_MFLO; #1;
      check("mflo_out", bus.Out, 32'h0000_5678);
      exp_hi = 32'hCAFE_0001;

      bus.Start = 1'b1; bus.MDUOp = 4'hF; bus.A = 32'd3; bus.B = 32'd3; #1;
      check("op15_out", bus.Out, 32'h0);
      tick();
      check("op15_busy", 32'(bus.Busy), 32'h0);
      bus.Start = 1'b0; bus.MDUOp = MDU_NULL;

      // Back-to-back: DIVU held on Start throughout the MULT, accepted once Busy drops.
      bus.Start = 1'b1; bus.MDUOp = MDU_MULT; bus.A = 32'd5; bus.B = 32'd6;
      tick();
      bus.MDUOp = MDU_DIVU; bus.A = 32'd100; bus.B = 32'd7;
      cycles = 0;
      while (bus.Busy && cycles < 64) begin
         cycles++;
         tick();
      end
      check("b2b_mult_len", 32'(cycles), 32'd5);
      check("b2b_mult_hi",  bus.HI, 32'h0);
      check("b2b_mult_lo",  bus.LO, 32'd30);
      tick();
      bus.Start = 1'b0; bus.MDUOp = MDU_NULL;
      cycles = 0;
      while (bus.Busy && cycles < 64) begin
         cycles++;
         tick();
      end
      check("b2b_divu_len", 32'(cycles), 32'd10);
      check("b2b_divu_hi",  bus.HI, 32'd2);
      check("b2b_divu_lo",  bus.LO, 32'd14);

      bus.MDUOp = MDU_MTHI; bus.A = 32'h0000_0077; tick();
      bus.Start = 1'b1; bus.MDUOp = MDU_DIV; bus.A = 32'hFFFF_FFF9; bus.B = 32'd2;
      tick();
      bus.Start = 1'b0; bus.MDUOp = MDU_NULL;
      repeat (2) tick();
      check("midrun_busy", 32'(bus.Busy), 32'h1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("midrun_rst_busy", 32'(bus.Busy), 32'h0);
      check("midrun_rst_hi",   bus.HI, 32'h0);
      check("midrun_rst_lo",   bus.LO, 32'h0);
      repeat (12) tick();
      check("midrun_rst_hi_late", bus.HI, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
